// File: rtl/rv_pkg.sv
// Shared front-end definitions.
// - if_state_e : ifetch FSM encoding (IF_RUN, IF_DRAIN)
// - NOP        : canonical RISC-V nop (addi x0,x0,0)
// - pc_mode_e  : PC update modes; glue maps ifetch pc_adv_o to INCR/STALL
package rv_pkg;

    typedef enum logic {
        IF_RUN   = 1'b0,
        IF_DRAIN = 1'b1
    } if_state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        STALL  = 2'd0,
        INCR   = 2'd1,
        BRANCH = 2'd2,
        JALR   = 2'd3
    } pc_mode_e;

    function automatic pc_mode_e pc_mode_from_adv(input logic adv);
        return adv ? INCR : STALL;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO with clear, used for the in-flight PC queue and the
// instruction queue of ifetch.
// Ports: clk, rst (sync, active-high), clr (drop contents), push/wdata,
//        pop, rdata (head entry, read from registered storage), count.
// Caller guarantees no push when full and no pop when empty.
module ifetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;

    // Storage is reset so the head reads zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + AW'(1);
            end
            if (pop) rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rptr];

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage.
// Issues word fetches at pc_i over a req/gnt port, tracks in-flight PCs,
// pairs in-order responses with their PC in an instruction queue and hands
// entries to decode over valid/ready. A flush drops everything queued and
// silently discards responses still owed by memory (DRAIN state).
// Ports: clk, rst (sync, active-high); pc_i/pc_adv_o to the PC;
//        flush_i redirect; imem_* memory port; id_* decode port.
// Optional feature macro IFETCH_MISALIGN_CHK_EN: a misaligned pc_i is not
// fetched; a nop entry flagged id_misalign_o is queued instead and fetch
// halts until the next flush.
module ifetch
    import rv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    output logic            pc_adv_o,
    input  logic            flush_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            id_valid_o,
    output logic [XLEN-1:0] id_instr_o,
    output logic [XLEN-1:0] id_pc_o,
`ifdef IFETCH_MISALIGN_CHK_EN
    output logic            id_misalign_o,
`endif
    input  logic            id_ready_i
);
    localparam int CW = $clog2(DEPTH) + 1;
`ifdef IFETCH_MISALIGN_CHK_EN
    localparam int EW = 2*XLEN + 1;
`else
    localparam int EW = 2*XLEN;
`endif

    if_state_e       state;
    logic [CW-1:0]   outst, q_count, discard;
    logic [XLEN-1:0] resp_pc;
    logic [EW-1:0]   ent_w, ent_r;
    logic            credit, can_fetch, issue, resp_ok, pop, iq_push;

    assign id_valid_o = (q_count != '0);
    assign pop        = id_valid_o && id_ready_i && !flush_i;

    // A slot freed by this cycle's decode pop counts as free, otherwise a
    // DEPTH=2 queue cannot sustain one instruction per cycle.
    assign credit = (int'(q_count) + int'(outst) - int'(pop)) < DEPTH;

`ifdef IFETCH_MISALIGN_CHK_EN
    logic halted, misal, mis_push;
    assign can_fetch = !rst && !flush_i && (state == IF_RUN) && credit && !halted;
    assign misal     = (pc_i[1:0] != 2'b00);
    // Wait for older fetches to land so the flagged entry stays in order.
    assign mis_push  = can_fetch && misal && (outst == '0);
    assign imem_req_o = can_fetch && !misal;
    assign ent_w = mis_push ? {pc_i, XLEN'(NOP), 1'b1} : {resp_pc, imem_rdata_i, 1'b0};
    assign {id_pc_o, id_instr_o, id_misalign_o} = ent_r;
    assign iq_push = (resp_ok && !flush_i) || mis_push;

    always_ff @(posedge clk) begin
        if (rst || flush_i) halted <= 1'b0;
        else if (mis_push)  halted <= 1'b1;
    end
`else
    assign can_fetch  = !rst && !flush_i && (state == IF_RUN) && credit;
    assign imem_req_o = can_fetch;
    assign ent_w      = {resp_pc, imem_rdata_i};
    assign {id_pc_o, id_instr_o} = ent_r;
    assign iq_push    = resp_ok && !flush_i;
`endif

    assign imem_addr_o = pc_i;
    assign issue       = imem_req_o && imem_gnt_i;
    assign pc_adv_o    = issue;
    // Responses with nothing tracked are a protocol error and are ignored.
    assign resp_ok     = imem_rvalid_i && (state == IF_RUN) && (outst != '0);

    ifetch_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_pcq (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush_i),
        .push  (issue),
        .wdata (pc_i),
        .pop   (resp_ok),
        .rdata (resp_pc),
        .count (outst)
    );

    ifetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_iq (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush_i),
        .push  (iq_push),
        .wdata (ent_w),
        .pop   (pop),
        .rdata (ent_r),
        .count (q_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IF_RUN;
            discard <= '0;
        end else if (state == IF_RUN) begin
            if (flush_i) begin
                // A response landing with the flush is dropped, not owed.
                discard <= outst - CW'(resp_ok);
                if (outst != CW'(resp_ok)) state <= IF_DRAIN;
            end
        end else begin
            // A flush while draining adds nothing: no requests went out.
            if (imem_rvalid_i) begin
                discard <= discard - CW'(1);
                if (discard == CW'(1)) state <= IF_RUN;
            end
        end
    end

    a_no_stray_rvalid : assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid_i && (outst == '0) && (discard == '0)));

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;
    localparam int DEPTH = 2;
`ifdef IFETCH_MISALIGN_CHK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk, rst, flush_i, pc_adv_o, imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic        id_valid_o, id_ready_i;
    logic [31:0] pc_i, imem_addr_o, imem_rdata_i, id_instr_o, id_pc_o;
`ifdef IFETCH_MISALIGN_CHK_EN
    logic        id_misalign_o;
`endif

    ifetch #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .pc_adv_o(pc_adv_o), .flush_i(flush_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .id_valid_o(id_valid_o), .id_instr_o(id_instr_o), .id_pc_o(id_pc_o),
`ifdef IFETCH_MISALIGN_CHK_EN
        .id_misalign_o(id_misalign_o),
`endif
        .id_ready_i(id_ready_i));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; logic mis; } ent_t;

    int ncmp = 0, nfail = 0, cyc = 0;
    int gnt_pct = 100, lat_min = 1, lat_max = 1;
    logic [31:0] pc, flush_tgt;

    mreq_t mq[$];          // memory: accepted requests awaiting response
    ent_t  iq[$];          // reference: entries waiting for decode
    logic [31:0] ifl[$];   // reference: fetched PCs still owed by memory
    int discard = 0;
    bit halted = 0;
    int g_cyc[$], p_cyc[$];
    logic [31:0] p_pc[$];

    bit rv_now, e_req, e_adv, e_valid, e_pop, e_mis_push, e_mis;
    logic [31:0] e_pc, e_ins;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    // Drive memory/PC inputs for this cycle and predict the outputs.
    task automatic drive();
        int qs;
        bit mis, base;
        pc_i          = pc;
        rv_now        = !rst && mq.size() > 0 && mq[0].due <= cyc;
        imem_rvalid_i = rv_now;
        imem_rdata_i  = rv_now ? mdata(mq[0].addr) : $urandom();
        imem_gnt_i    = (int'($urandom_range(99)) < gnt_pct);
        #2;
        qs         = iq.size();
        e_pop      = qs > 0 && id_ready_i && !flush_i;
        mis        = MIS && (pc[1:0] != 2'b00);
        base       = !flush_i && discard == 0 && !halted && (qs + ifl.size() - int'(e_pop)) < DEPTH;
        e_req      = base && !mis;
        e_mis_push = base && mis && ifl.size() == 0;
        e_adv      = e_req && imem_gnt_i;
        e_valid    = qs != 0;
        e_pc       = qs != 0 ? iq[0].pc  : 32'h0;
        e_ins      = qs != 0 ? iq[0].ins : 32'h0;
        e_mis      = qs != 0 ? iq[0].mis : 1'b0;
    endtask

    // Update reference, memory and PC, then cross the clock edge.
    task automatic advance();
        mreq_t m;
        ent_t  e;
        if (rst) begin
            iq.delete(); ifl.delete(); mq.delete();
            discard = 0; halted = 0;
        end else begin
            if (flush_i) begin
                if (discard == 0) discard = ifl.size() - ((rv_now && ifl.size() > 0) ? 1 : 0);
                else if (rv_now) discard--;
                iq.delete(); ifl.delete(); halted = 0;
            end else if (discard > 0) begin
                if (rv_now) discard--;
            end else begin
                if (e_pop) iq.delete(0);
                if (rv_now && ifl.size() > 0) begin
                    e.pc = ifl[0]; e.ins = mdata(ifl[0]); e.mis = 1'b0;
                    ifl.delete(0);
                    iq.push_back(e);
                end
                if (e_mis_push) begin
                    e.pc = pc; e.ins = 32'h0000_0013; e.mis = 1'b1;
                    iq.push_back(e);
                    halted = 1;
                end
                if (e_req && imem_gnt_i) ifl.push_back(pc);
            end
            if (imem_req_o && imem_gnt_i) g_cyc.push_back(cyc);
            if (id_valid_o && id_ready_i && !flush_i) begin
                p_cyc.push_back(cyc); p_pc.push_back(id_pc_o);
            end
            if (rv_now) mq.delete(0);
            if (imem_req_o && imem_gnt_i) begin
                m.addr = pc_i; m.due = cyc + int'($urandom_range(lat_max, lat_min));
                mq.push_back(m);
            end
            if (flush_i) pc = flush_tgt;
            else if (pc_adv_o) pc = pc + 32'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input logic [31:0] p0);
        rst = 1; flush_i = 0; pc = p0; gnt_pct = 100; lat_min = 1; lat_max = 1;
        repeat (2) begin drive(); advance(); end
        rst = 0; cyc = 0;
        g_cyc.delete(); p_cyc.delete(); p_pc.delete();
    endtask

    task automatic test_reset();
        rst = 1; flush_i = 0; id_ready_i = 1; pc = 32'h80; gnt_pct = 100;
        repeat (2) begin drive(); advance(); end
        drive();
        ncmp++; if (imem_req_o !== 1'b0) begin nfail++; $display("FAIL rst_req got %b want 0", imem_req_o); end
        ncmp++; if (pc_adv_o !== 1'b0) begin nfail++; $display("FAIL rst_adv got %b want 0", pc_adv_o); end
        ncmp++; if (id_valid_o !== 1'b0) begin nfail++; $display("FAIL rst_valid got %b want 0", id_valid_o); end
        ncmp++; if (id_instr_o !== 32'h0) begin nfail++; $display("FAIL rst_instr got %h want 0", id_instr_o); end
        ncmp++; if (id_pc_o !== 32'h0) begin nfail++; $display("FAIL rst_pc got %h want 0", id_pc_o); end
`ifdef IFETCH_MISALIGN_CHK_EN
        ncmp++; if (id_misalign_o !== 1'b0) begin nfail++; $display("FAIL rst_mis got %b want 0", id_misalign_o); end
`endif
        advance();
        rst = 0; cyc = 0;
        drive();
        ncmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h80) begin
            nfail++; $display("FAIL post_rst_req got %b/%h want 1/00000080", imem_req_o, imem_addr_o);
        end
        advance();
    endtask

    task automatic test_stream();
        do_reset(32'h0); id_ready_i = 1;
        repeat (8) begin drive(); advance(); end
        ncmp++; if (g_cyc.size() < 1 || g_cyc[0] != 0) begin
            nfail++; $display("FAIL stream_first_gnt got %0d grants want first at cycle 0", g_cyc.size());
        end
        for (int k = 0; k < 4; k++) begin
            ncmp++;
            if (p_pc.size() <= k || p_pc[k] !== 32'(4*k) || p_cyc[k] != 2 + k) begin
                nfail++;
                $display("FAIL stream_pop%0d got pc %h cyc %0d want pc %h cyc %0d", k,
                         p_pc.size() > k ? p_pc[k] : 32'hx, p_cyc.size() > k ? p_cyc[k] : -1, 4*k, 2 + k);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(32'h0); id_ready_i = 0;
        repeat (5) begin drive(); advance(); end
        drive();
        ncmp++; if (g_cyc.size() != 2) begin nfail++; $display("FAIL bp_grants got %0d want 2", g_cyc.size()); end
        ncmp++; if (imem_req_o !== 1'b0) begin nfail++; $display("FAIL bp_req got %b want 0", imem_req_o); end
        ncmp++; if (pc_adv_o !== 1'b0) begin nfail++; $display("FAIL bp_adv got %b want 0", pc_adv_o); end
        ncmp++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h0) begin
            nfail++; $display("FAIL bp_head got %b/%h want 1/00000000", id_valid_o, id_pc_o);
        end
        advance();
        id_ready_i = 1;
        repeat (3) begin drive(); advance(); end
        ncmp++; if (p_pc.size() < 2 || p_pc[0] !== 32'h0 || p_pc[1] !== 32'h4) begin
            nfail++; $display("FAIL bp_order got %0d pops first %h want 00000000 then 00000004",
                              p_pc.size(), p_pc.size() > 0 ? p_pc[0] : 32'hx);
        end
    endtask

    task automatic test_flush_drain();
        int req_c, nvalid;
        do_reset(32'h0); id_ready_i = 1; lat_min = 3; lat_max = 3;
        repeat (2) begin drive(); advance(); end
        ncmp++; if (g_cyc.size() != 2) begin nfail++; $display("FAIL drain_grants got %0d want 2", g_cyc.size()); end
        flush_i = 1; flush_tgt = 32'h100;
        drive();
        ncmp++; if (imem_req_o !== 1'b0) begin nfail++; $display("FAIL drain_flush_req got %b want 0", imem_req_o); end
        advance();
        flush_i = 0; req_c = -1; nvalid = 0;
        for (int i = 0; i < 12 && req_c < 0; i++) begin
            drive();
            if (id_valid_o) nvalid++;
            if (imem_req_o) begin
                req_c = cyc;
                ncmp++; if (imem_addr_o !== 32'h100) begin
                    nfail++; $display("FAIL drain_addr got %h want 00000100", imem_addr_o);
                end
            end
            advance();
        end
        ncmp++; if (req_c != 5) begin nfail++; $display("FAIL drain_req_cycle got %0d want 5", req_c); end
        ncmp++; if (nvalid != 0) begin nfail++; $display("FAIL drain_valid got %0d pulses want 0", nvalid); end
    endtask

    task automatic test_flush_same_cycle();
        do_reset(32'h0); id_ready_i = 1;
        repeat (2) begin drive(); advance(); end
        flush_i = 1; flush_tgt = 32'h200;
        drive();   // head PC0 popped and PC4 response landing, both with the flush
        ncmp++; if (id_valid_o !== 1'b1 || imem_req_o !== 1'b0) begin
            nfail++; $display("FAIL fsame_pre got valid %b req %b want 1/0", id_valid_o, imem_req_o);
        end
        advance();
        flush_i = 0;
        drive();
        ncmp++; if (id_valid_o !== 1'b0) begin nfail++; $display("FAIL fsame_empty got %b want 0", id_valid_o); end
        ncmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
            nfail++; $display("FAIL fsame_req got %b/%h want 1/00000200", imem_req_o, imem_addr_o);
        end
        advance();
        drive();
        ncmp++; if (id_valid_o !== 1'b0) begin nfail++; $display("FAIL fsame_gap got %b want 0", id_valid_o); end
        advance();
        drive();
        ncmp++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h200 || id_instr_o !== mdata(32'h200)) begin
            nfail++; $display("FAIL fsame_new got %b/%h/%h want 1/00000200/%h",
                              id_valid_o, id_pc_o, id_instr_o, mdata(32'h200));
        end
        advance();
    endtask

    task automatic test_gnt_stall();
        do_reset(32'h40); id_ready_i = 1; gnt_pct = 0;
        for (int i = 0; i < 5; i++) begin
            drive();
            ncmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40 || pc_adv_o !== 1'b0) begin
                nfail++; $display("FAIL stall%0d got req %b addr %h adv %b want 1/00000040/0",
                                  i, imem_req_o, imem_addr_o, pc_adv_o);
            end
            advance();
        end
        gnt_pct = 100;
        drive();
        ncmp++; if (pc_adv_o !== 1'b1) begin nfail++; $display("FAIL stall_release got %b want 1", pc_adv_o); end
        advance();
    endtask

`ifdef IFETCH_MISALIGN_CHK_EN
    task automatic test_misalign();
        do_reset(32'h102); id_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            drive();
            ncmp++; if (imem_req_o !== 1'b0 || pc_adv_o !== 1'b0) begin
                nfail++; $display("FAIL mis_req%0d got %b/%b want 0/0", i, imem_req_o, pc_adv_o);
            end
            advance();
        end
        drive();
        ncmp++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h102 || id_instr_o !== 32'h13 || id_misalign_o !== 1'b1) begin
            nfail++; $display("FAIL mis_entry got %b/%h/%h/%b want 1/00000102/00000013/1",
                              id_valid_o, id_pc_o, id_instr_o, id_misalign_o);
        end
        advance();
        flush_i = 1; flush_tgt = 32'h200; drive(); advance(); flush_i = 0;
        drive();
        ncmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
            nfail++; $display("FAIL mis_resume got %b/%h want 1/00000200", imem_req_o, imem_addr_o);
        end
        advance();
    endtask
`endif

    task automatic test_random();
        do_reset($urandom() & 32'h0000_FFFC);
        gnt_pct = 75; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 1500; i++) begin
            id_ready_i = ($urandom_range(99) < 70);
            flush_i    = ($urandom_range(99) < 4);
            flush_tgt  = $urandom() & 32'hFFFF_FFFC;
`ifdef IFETCH_MISALIGN_CHK_EN
            if ($urandom_range(9) == 0) flush_tgt[1:0] = 2'b10;
`endif
            drive();
            ncmp++; if (imem_req_o !== e_req) begin nfail++; $display("FAIL rnd_req cyc %0d got %b want %b", cyc, imem_req_o, e_req); end
            ncmp++; if (pc_adv_o !== e_adv) begin nfail++; $display("FAIL rnd_adv cyc %0d got %b want %b", cyc, pc_adv_o, e_adv); end
            ncmp++; if (id_valid_o !== e_valid) begin nfail++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, id_valid_o, e_valid); end
            if (e_req) begin
                ncmp++; if (imem_addr_o !== pc) begin nfail++; $display("FAIL rnd_addr cyc %0d got %h want %h", cyc, imem_addr_o, pc); end
            end
            if (e_valid) begin
                ncmp++; if (id_pc_o !== e_pc || id_instr_o !== e_ins) begin
                    nfail++; $display("FAIL rnd_entry cyc %0d got %h/%h want %h/%h", cyc, id_pc_o, id_instr_o, e_pc, e_ins);
                end
`ifdef IFETCH_MISALIGN_CHK_EN
                ncmp++; if (id_misalign_o !== e_mis) begin nfail++; $display("FAIL rnd_mis cyc %0d got %b want %b", cyc, id_misalign_o, e_mis); end
`endif
            end
            advance();
        end
        flush_i = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; flush_i = 0; id_ready_i = 0; pc = 0; flush_tgt = 0;
        pc_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_drain();
        test_flush_same_cycle();
        test_gnt_stall();
`ifdef IFETCH_MISALIGN_CHK_EN
        test_misalign();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
